// File: rtl/arb_pkg.sv
// Shared types and helpers for the arb_grant_ctrl grant controller slice.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  localparam int GNT_CNT_W = 8;

  // Index width for n sources; a single source still needs one select bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_pend_reg.sv
// Pending-request register: per-bit set/clear where a simultaneous set wins.
module arb_pend_reg
  import arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] set_i,
  input  logic [N-1:0] clr_i,
  output logic [N-1:0] pend_o
);

  // A source re-requesting in its own acceptance cycle must stay pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_o <= '0;
    end else begin
      pend_o <= (pend_o & ~clr_i) | set_i;
    end
  end

endmodule

// File: rtl/arb_grant_ctrl.sv
// Sequential grant controller around an external priority arbiter.
// Optional macro ARB_GRANT_PREEMPT_EN: a strictly better winner may replace an unaccepted grant.
module arb_grant_ctrl
  import arb_pkg::*;
#(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3,
  parameter int TIMEOUT   = 255,
  localparam int SEL_W    = sel_w(N)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_set_i,
  output logic [N-1:0]         pend_o,
  input  logic                 arb_req_i,
  input  logic [SEL_W-1:0]     arb_sel_i,
  input  logic [PRIO_BITS-1:0] arb_prio_i,
  output logic                 gnt_valid_o,
  input  logic                 gnt_ready_i,
  output logic [SEL_W-1:0]     gnt_sel_o,
  output logic [PRIO_BITS-1:0] gnt_prio_o,
  input  logic                 done_i,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [GNT_CNT_W-1:0] gnt_cnt_o
);

  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e             state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [PRIO_BITS-1:0]   prio_q, prio_d;
  logic [GNT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;
  logic                   accept;
  logic                   tmo_hit;
  logic [N-1:0]           pend_clr;

  arb_pend_reg #(.N(N)) u_pend (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .set_i  (req_set_i),
    .clr_i  (pend_clr),
    .pend_o (pend_o)
  );

  always_comb begin
    pend_clr = '0;
    for (int k = 0; k < N; k++) begin
      pend_clr[k] = accept && (sel_q == SEL_W'(k));
    end
  end

  // BUSY-cycle counter exists only when a timeout is configured.
  if (TIMEOUT != 0) begin : g_tmo
    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        tmo_cnt_q <= '0;
      end else if (state_q == BUSY) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
    end

    assign tmo_hit = (state_q == BUSY) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
  end else begin : g_no_tmo
    assign tmo_hit = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      prio_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_req_i) begin
          sel_d   = arb_sel_i;
          prio_d  = arb_prio_i;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Acceptance takes priority, so a same-cycle replacement never lands.
        if (gnt_ready_i) begin
          accept  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = BUSY;
        end
`ifdef ARB_GRANT_PREEMPT_EN
        else if (arb_req_i && (arb_prio_i < prio_q)) begin
          sel_d  = arb_sel_i;
          prio_d = arb_prio_i;
        end
`endif
      end
      BUSY: begin
        if (done_i) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_valid_o = (state_q == GRANT);
  assign busy_o      = (state_q == BUSY);
  assign gnt_sel_o   = sel_q;
  assign gnt_prio_o  = prio_q;
  assign gnt_cnt_o   = cnt_q;
  assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// Self-checking bench for arb_grant_ctrl with a behavioural arbiter and a grant scoreboard.
module tb_arb_grant_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] prio;
  } gnt_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_set;
  logic [7:0] pend;
  logic       arb_req;
  logic [2:0] arb_sel;
  logic [2:0] arb_prio;
  logic       gnt_valid;
  logic       gnt_ready;
  logic [2:0] gnt_sel;
  logic [2:0] gnt_prio;
  logic       done;
  logic       busy;
  logic       timeout;
  logic [7:0] gnt_cnt;

  logic [2:0] src_prio [8];
  gnt_t       exp_q [$];
  int         total = 0;
  int         bad = 0;

  arb_grant_ctrl #(.N(8), .PRIO_BITS(3), .TIMEOUT(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_set_i   (req_set),
    .pend_o      (pend),
    .arb_req_i   (arb_req),
    .arb_sel_i   (arb_sel),
    .arb_prio_i  (arb_prio),
    .gnt_valid_o (gnt_valid),
    .gnt_ready_i (gnt_ready),
    .gnt_sel_o   (gnt_sel),
    .gnt_prio_o  (gnt_prio),
    .done_i      (done),
    .busy_o      (busy),
    .timeout_o   (timeout),
    .gnt_cnt_o   (gnt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbiter: lowest priority value wins, lowest index breaks ties.
  always_comb begin
    arb_req  = 1'b0;
    arb_sel  = 3'd0;
    arb_prio = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (pend[k] && (!arb_req || src_prio[k] < arb_prio)) begin
        arb_req  = 1'b1;
        arb_sel  = 3'(k);
        arb_prio = src_prio[k];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] req);
    req_set = req;
    tick();
    req_set = 8'h00;
  endtask

  task automatic waitValid(input string tag);
    for (int i = 0; i < 20 && !gnt_valid; i++) tick();
    checkOutput(tag, 32'(gnt_valid), 32'd1);
  endtask

  // Assumes gnt_ready is high: accept now, then done on the given BUSY cycle.
  task automatic serveGrant(input string tag, input int done_cycle);
    waitValid(tag);
    tick();
    repeat (done_cycle - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Every accepted handshake is matched against the next expected grant.
  always @(negedge clk) begin
    if (rst_n && gnt_valid && gnt_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_grant_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        gnt_t e;
        e = exp_q.pop_front();
        checkOutput("sb_sel", 32'(gnt_sel), 32'(e.sel));
        checkOutput("sb_prio", 32'(gnt_prio), 32'(e.prio));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    src_prio = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd2, 3'd3, 3'd1, 3'd7};
    rst_n     = 1'b0;
    req_set   = 8'h00;
    gnt_ready = 1'b0;
    done      = 1'b0;
    #12;
    checkOutput("rst_pend", 32'(pend), 32'd0);
    checkOutput("rst_valid", 32'(gnt_valid), 32'd0);
    checkOutput("rst_sel", 32'(gnt_sel), 32'd0);
    checkOutput("rst_prio", 32'(gnt_prio), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_cnt", 32'(gnt_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    $display("[TB] test 1: single request latency");
    gnt_ready = 1'b1;
    exp_q.push_back('{sel: 3'd2, prio: 3'd5});
    applyStimulus(8'b0000_0100);
    checkOutput("t1_pend_t1", 32'(pend), 32'h04);
    checkOutput("t1_valid_t1", 32'(gnt_valid), 32'd0);
    tick();
    checkOutput("t1_valid_t2", 32'(gnt_valid), 32'd1);
    checkOutput("t1_sel", 32'(gnt_sel), 32'd2);
    checkOutput("t1_prio", 32'(gnt_prio), 32'd5);
    tick();
    checkOutput("t1_pend_cleared", 32'(pend), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_cnt", 32'(gnt_cnt), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t1_released", 32'(busy), 32'd0);

    $display("[TB] test 2: two sources, priority order");
    exp_q.push_back('{sel: 3'd6, prio: 3'd1});
    exp_q.push_back('{sel: 3'd1, prio: 3'd4});
    applyStimulus(8'b0100_0010);
    checkOutput("t2_pend", 32'(pend), 32'h42);
    serveGrant("t2_first_valid", 3);
    serveGrant("t2_second_valid", 3);
    checkOutput("t2_cnt", 32'(gnt_cnt), 32'd3);
    checkOutput("t2_pend_empty", 32'(pend), 32'd0);

    $display("[TB] test 3: payload stable while not accepted");
    gnt_ready = 1'b0;
    exp_q.push_back('{sel: 3'd5, prio: 3'd3});
    exp_q.push_back('{sel: 3'd0, prio: 3'd0});
    applyStimulus(8'b0010_0000);
    tick();
    for (int i = 0; i < 10; i++) begin
      req_set = (i == 2) ? 8'h01 : 8'h00;
      tick();
      checkOutput("t3_hold", 32'({gnt_valid, gnt_sel, gnt_prio}), 32'({1'b1, 3'd5, 3'd3}));
    end
    req_set   = 8'h00;
    checkOutput("t3_pend_accum", 32'(pend), 32'h21);
    gnt_ready = 1'b1;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    serveGrant("t3_src0_valid", 1);
    checkOutput("t3_cnt", 32'(gnt_cnt), 32'd5);

    $display("[TB] test 4: timeout");
    exp_q.push_back('{sel: 3'd4, prio: 3'd2});
    applyStimulus(8'b0001_0000);
    tick();
    tick();
    n = 0;
    for (int i = 0; i < 10 && busy; i++) begin
      checkOutput("t4_no_early_tmo", 32'(timeout), 32'd0);
      n++;
      tick();
    end
    checkOutput("t4_busy_cycles", 32'(n), 32'd4);
    checkOutput("t4_tmo_pulse", 32'(timeout), 32'd1);
    tick();
    checkOutput("t4_tmo_single", 32'(timeout), 32'd0);
    checkOutput("t4_idle", 32'(gnt_valid), 32'd0);
    exp_q.push_back('{sel: 3'd4, prio: 3'd2});
    applyStimulus(8'b0001_0000);
    tick();
    tick();
    repeat (3) tick();
    checkOutput("t4_busy_4th", 32'(busy), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t4_done_no_tmo", 32'(timeout), 32'd0);
    checkOutput("t4_done_release", 32'(busy), 32'd0);
    checkOutput("t4_cnt", 32'(gnt_cnt), 32'd7);

    $display("[TB] test 5: re-request during acceptance");
    gnt_ready = 1'b0;
    exp_q.push_back('{sel: 3'd3, prio: 3'd6});
    exp_q.push_back('{sel: 3'd3, prio: 3'd6});
    applyStimulus(8'b0000_1000);
    tick();
    gnt_ready = 1'b1;
    req_set   = 8'b0000_1000;
    tick();
    req_set   = 8'h00;
    checkOutput("t5_pend_kept", 32'(pend[3]), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t5_gap", 32'(gnt_valid), 32'd0);
    tick();
    checkOutput("t5_regrant", 32'(gnt_valid), 32'd1);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t5_cnt", 32'(gnt_cnt), 32'd9);

    $display("[TB] test 6: async reset during BUSY");
    exp_q.push_back('{sel: 3'd6, prio: 3'd1});
    req_set = 8'hF0;
    tick();
    tick();
    tick();
    req_set = 8'h00;
    checkOutput("t6_busy", 32'(busy), 32'd1);
    checkOutput("t6_pend", 32'(pend), 32'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_pend", 32'(pend), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_valid", 32'(gnt_valid), 32'd0);
    checkOutput("t6_rst_payload", 32'({gnt_sel, gnt_prio}), 32'd0);
    checkOutput("t6_rst_cnt", 32'(gnt_cnt), 32'd0);
    checkOutput("t6_rst_timeout", 32'(timeout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t6_no_grant", 32'({gnt_valid, pend}), 32'd0);
    end
    checkOutput("sb_all_consumed", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
